// File: rtl/rv_pkg.sv
// rv_pkg: shared opcodes, ALU op codes, write-back/PC-source encodings and CSR addresses
package rv_pkg;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_XOR   = 4'b0010,
        ALU_ADD   = 4'b0011,
        ALU_SUB   = 4'b0100,
        ALU_MUL   = 4'b0101,
        ALU_MULH  = 4'b0110,
        ALU_MULHU = 4'b0111,
        ALU_SLL   = 4'b1000,
        ALU_SRL   = 4'b1001,
        ALU_SRA   = 4'b1010,
        ALU_SLT   = 4'b1100,
        ALU_SLTU  = 4'b1101
    } alu_op_e;
    localparam logic [1:0] SEL_SW   = 2'b00;
    localparam logic [1:0] SEL_LUI  = 2'b01;
    localparam logic [1:0] SEL_ALU  = 2'b10;
    localparam logic [1:0] SEL_LINK = 2'b11;
    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JAL  = 2'b10;
    localparam logic [1:0] PC_JALR = 2'b11;
    localparam logic [11:0] CSR_SW  = 12'hF00;
    localparam logic [11:0] CSR_HEX = 12'hF02;
endpackage

// File: rtl/rv_alu.sv
// rv_alu: combinational RV32I-subset ALU with the M-extension multiplies
module rv_alu
    import rv_pkg::*;
(
    input  alu_op_e     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_r
);
    logic [63:0] w_prod;
    logic [31:0] w_mulh;
    assign w_prod = {32'b0, i_a} * {32'b0, i_b};
    // signed high word derived from the unsigned product so one multiplier serves all three ops
    assign w_mulh = w_prod[63:32] - (i_a[31] ? i_b : 32'b0) - (i_b[31] ? i_a : 32'b0);
    always_comb begin
        case (i_op)
            ALU_AND:   o_r = i_a & i_b;
            ALU_OR:    o_r = i_a | i_b;
            ALU_XOR:   o_r = i_a ^ i_b;
            ALU_ADD:   o_r = i_a + i_b;
            ALU_SUB:   o_r = i_a - i_b;
            ALU_MUL:   o_r = w_prod[31:0];
            ALU_MULH:  o_r = w_mulh;
            ALU_MULHU: o_r = w_prod[63:32];
            ALU_SLL:   o_r = i_a << i_b[4:0];
            ALU_SRL:   o_r = i_a >> i_b[4:0];
            ALU_SRA:   o_r = $signed(i_a) >>> i_b[4:0];
            ALU_SLT:   o_r = {31'b0, $signed(i_a) < $signed(i_b)};
            ALU_SLTU:  o_r = {31'b0, i_a < i_b};
            default:   o_r = 32'b0;
        endcase
    end
endmodule

// File: rtl/rv_decode.sv
// rv_decode: instruction field split and control table for the EX stage
module rv_decode
    import rv_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic [11:0] o_imm12,
    output logic [19:0] o_imm20,
    output alu_op_e     o_alu_op,
    output logic        o_alusrc,
    output logic        o_regwrite,
    output logic [1:0]  o_regsel,
    output logic        o_gpio_we,
    output logic [1:0]  o_jump,
    output logic        o_branch
);
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign o_rs1    = i_instr[19:15];
    assign o_rs2    = i_instr[24:20];
    assign o_rd     = i_instr[11:7];
    assign o_imm12  = i_instr[31:20];
    assign o_imm20  = i_instr[31:12];
    always_comb begin
        o_alu_op   = ALU_ADD;
        o_alusrc   = 1'b0;
        o_regwrite = 1'b0;
        o_regsel   = SEL_ALU;
        o_gpio_we  = 1'b0;
        o_jump     = PC_SEQ;
        o_branch   = 1'b0;
        case (w_opcode)
            OP_R: begin
                o_regwrite = 1'b1;
                case ({w_funct7, w_funct3})
                    10'b0000000_000: o_alu_op = ALU_ADD;
                    10'b0100000_000: o_alu_op = ALU_SUB;
                    10'b0000000_001: o_alu_op = ALU_SLL;
                    10'b0000000_010: o_alu_op = ALU_SLT;
                    10'b0000000_011: o_alu_op = ALU_SLTU;
                    10'b0000000_100: o_alu_op = ALU_XOR;
                    10'b0000000_101: o_alu_op = ALU_SRL;
                    10'b0100000_101: o_alu_op = ALU_SRA;
                    10'b0000000_110: o_alu_op = ALU_OR;
                    10'b0000000_111: o_alu_op = ALU_AND;
                    10'b0000001_000: o_alu_op = ALU_MUL;
                    10'b0000001_001: o_alu_op = ALU_MULH;
                    10'b0000001_011: o_alu_op = ALU_MULHU;
                    default:         o_regwrite = 1'b0;
                endcase
            end
            OP_I: begin
                o_alusrc   = 1'b1;
                o_regwrite = 1'b1;
                case (w_funct3)
                    3'b000:  o_alu_op = ALU_ADD;
                    3'b010:  o_alu_op = ALU_SLT;
                    3'b011:  o_alu_op = ALU_SLTU;
                    3'b100:  o_alu_op = ALU_XOR;
                    3'b110:  o_alu_op = ALU_OR;
                    3'b111:  o_alu_op = ALU_AND;
                    3'b001: begin
                        if (w_funct7 == 7'b0000000) o_alu_op = ALU_SLL;
                        else {o_alusrc, o_regwrite} = 2'b00;
                    end
                    default: begin
                        if (w_funct7 == 7'b0000000) o_alu_op = ALU_SRL;
                        else if (w_funct7 == 7'b0100000) o_alu_op = ALU_SRA;
                        else {o_alusrc, o_regwrite} = 2'b00;
                    end
                endcase
            end
            OP_LUI: begin
                o_regwrite = 1'b1;
                o_regsel   = SEL_LUI;
            end
            OP_SYS: begin
                if (w_funct3 == 3'b001 && o_imm12 == CSR_HEX) o_gpio_we = 1'b1;
                if (w_funct3 == 3'b001 && o_imm12 == CSR_SW) begin
                    o_regwrite = 1'b1;
                    o_regsel   = SEL_SW;
                end
            end
            OP_BR: begin
                // funct3 010/011 are not branches and fall through as undefined
                if (w_funct3[2:1] != 2'b01) begin
                    o_branch = 1'b1;
                    o_alu_op = w_funct3[2] ? (w_funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                end
            end
            OP_JAL: begin
                o_regwrite = 1'b1;
                o_regsel   = SEL_LINK;
                o_jump     = PC_JAL;
            end
            OP_JALR: begin
                if (w_funct3 == 3'b000) begin
                    o_regwrite = 1'b1;
                    o_regsel   = SEL_LINK;
                    o_jump     = PC_JALR;
                    o_alusrc   = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/rv_exec_ctrl.sv
// rv_exec_ctrl: EX-stage decode, ALU, branch resolution and one-cycle wrong-path squash
module rv_exec_ctrl
    import rv_pkg::*;
(
    input  logic        clck,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [11:0] imm12,
    output logic [19:0] imm20,
    output logic [31:0] alu_r,
    output logic        zero,
    output logic        regwrite,
    output logic [1:0]  regsel,
    output logic        gpio_we,
    output logic [1:0]  pcsrc,
    output logic        stall_fetch
);
    alu_op_e     w_alu_op;
    logic        w_alusrc;
    logic        w_regwrite;
    logic        w_gpio_we;
    logic [1:0]  w_jump;
    logic        w_branch;
    logic [31:0] w_b;
    logic        w_taken;
    logic        w_bubble;
    logic        r_stall_ex;
    rv_decode u_decode (
        .i_instr    (instr),
        .o_rs1      (rs1),
        .o_rs2      (rs2),
        .o_rd       (rd),
        .o_imm12    (imm12),
        .o_imm20    (imm20),
        .o_alu_op   (w_alu_op),
        .o_alusrc   (w_alusrc),
        .o_regwrite (w_regwrite),
        .o_regsel   (regsel),
        .o_gpio_we  (w_gpio_we),
        .o_jump     (w_jump),
        .o_branch   (w_branch)
    );
    assign w_b = w_alusrc ? {{20{instr[31]}}, instr[31:20]} : rs2_data;
    rv_alu u_alu (
        .i_op (w_alu_op),
        .i_a  (rs1_data),
        .i_b  (w_b),
        .o_r  (alu_r)
    );
    assign zero = (alu_r == 32'b0);
    // funct3[2] picks the compare bit over zero; funct3[0] inverts the condition
    assign w_taken     = w_branch & ((instr[14] ? alu_r[0] : zero) ^ instr[12]);
    assign w_bubble    = r_stall_ex | rst;
    assign pcsrc       = w_bubble ? PC_SEQ : (w_taken ? PC_BR : w_jump);
    assign stall_fetch = (pcsrc != PC_SEQ);
    assign regwrite    = w_regwrite & ~w_bubble;
    assign gpio_we     = w_gpio_we & ~w_bubble;
    always_ff @(posedge clck) begin
        if (rst) r_stall_ex <= 1'b0;
        else     r_stall_ex <= stall_fetch;
    end
endmodule

// File: tb/tb_rv_exec_ctrl.sv
// tb_rv_exec_ctrl: vector table through a scoreboard queue plus squash/reset sequences
module tb_rv_exec_ctrl;
    logic        clck = 1'b0;
    logic        rst;
    logic [31:0] instr, rs1_data, rs2_data;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] imm12;
    logic [19:0] imm20;
    logic [31:0] alu_r;
    logic        zero, regwrite, gpio_we, stall_fetch;
    logic [1:0]  regsel, pcsrc;
    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] alu;
        logic        rw;
        logic        gw;
        logic [1:0]  rs;
        logic [1:0]  pc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    rv_exec_ctrl dut (
        .clck(clck), .rst(rst), .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm12(imm12), .imm20(imm20), .alu_r(alu_r),
        .zero(zero), .regwrite(regwrite), .regsel(regsel), .gpio_we(gpio_we),
        .pcsrc(pcsrc), .stall_fetch(stall_fetch)
    );

    always #5 clck = ~clck;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [6:0] op);
        return {imm, 5'd1, f3, 5'd3, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3);
        return {7'b0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
    endfunction

    task automatic add_vec(input logic [31:0] i, a, b, alu, input logic rw, gw, input logic [1:0] rs, pc);
        vec_t v;
        v.instr = i; v.a = a; v.b = b; v.alu = alu; v.rw = rw; v.gw = gw; v.rs = rs; v.pc = pc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        @(negedge clck);
        instr = i; rs1_data = a; rs2_data = b;
        #1;
    endtask

    initial begin
        vec_t e;
        add_vec(enc_r(7'h00, 3'b000), 32'd7, 32'd5, 32'd12, 1, 0, 2'b10, 2'b00);
        add_vec(enc_r(7'h20, 3'b000), 32'd7, 32'd5, 32'd2, 1, 0, 2'b10, 2'b00);
        add_vec(enc_r(7'h01, 3'b001), 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 1, 0, 2'b10, 2'b00);
        add_vec(enc_r(7'h01, 3'b011), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0, 2'b10, 2'b00);
        add_vec(enc_r(7'h01, 3'b000), 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1, 0, 2'b10, 2'b00);
        add_vec(enc_i(12'h404, 3'b101, 7'b0010011), 32'h8000_0000, 32'd0, 32'hF800_0000, 1, 0, 2'b10, 2'b00);
        add_vec(enc_i(12'h004, 3'b101, 7'b0010011), 32'h8000_0000, 32'd0, 32'h0800_0000, 1, 0, 2'b10, 2'b00);
        add_vec(enc_i(12'hFFF, 3'b011, 7'b0010011), 32'd1, 32'd0, 32'd1, 1, 0, 2'b10, 2'b00);
        add_vec(enc_r(7'h00, 3'b010), 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 0, 2'b10, 2'b00);
        add_vec(enc_r(7'h00, 3'b001), 32'd1, 32'h23, 32'd8, 1, 0, 2'b10, 2'b00);
        add_vec(enc_i(12'h0F0, 3'b100, 7'b0010011), 32'hFF, 32'd0, 32'h0F, 1, 0, 2'b10, 2'b00);
        add_vec(enc_i(12'h00F, 3'b110, 7'b0010011), 32'hF0, 32'd0, 32'hFF, 1, 0, 2'b10, 2'b00);
        add_vec(enc_b(3'b000), 32'd5, 32'd5, 32'd0, 0, 0, 2'b00, 2'b01);
        add_vec(enc_b(3'b001), 32'd5, 32'd5, 32'd0, 0, 0, 2'b00, 2'b00);
        add_vec(enc_b(3'b111), 32'd1, 32'hFFFF_FFFF, 32'd1, 0, 0, 2'b00, 2'b00);
        add_vec(enc_b(3'b100), 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 2'b00, 2'b01);
        add_vec({20'd0, 5'd1, 7'b1101111}, 32'd0, 32'd0, 32'd0, 1, 0, 2'b11, 2'b10);
        add_vec(enc_i(12'd8, 3'b000, 7'b1100111), 32'h100, 32'd0, 32'h108, 1, 0, 2'b11, 2'b11);
        add_vec(enc_i(12'hF02, 3'b001, 7'b1110011), 32'd0, 32'd0, 32'd0, 0, 1, 2'b00, 2'b00);
        add_vec(enc_i(12'hF00, 3'b001, 7'b1110011), 32'd0, 32'd0, 32'd0, 1, 0, 2'b00, 2'b00);
        add_vec(enc_i(12'h123, 3'b001, 7'b1110011), 32'd0, 32'd0, 32'd0, 0, 0, 2'b00, 2'b00);
        add_vec({20'h12345, 5'd3, 7'b0110111}, 32'd0, 32'd0, 32'd0, 1, 0, 2'b01, 2'b00);
        add_vec(32'h0000_0000, 32'd3, 32'd4, 32'd7, 0, 0, 2'b00, 2'b00);

        rst = 1'b1; instr = NOP; rs1_data = 0; rs2_data = 0;
        @(posedge clck);
        // enables held off while rst is high even for a taken branch / GPIO write
        drive(enc_b(3'b000), 32'd0, 32'd0);
        chk("rst pcsrc", 32'(pcsrc), 32'd0);
        chk("rst stall_fetch", 32'(stall_fetch), 32'd0);
        drive(enc_i(12'hF02, 3'b001, 7'b1110011), 32'd0, 32'd0);
        chk("rst gpio_we", 32'(gpio_we), 32'd0);
        drive(enc_i(12'd5, 3'b000, 7'b0010011), 32'd2, 32'd0);
        chk("rst regwrite", 32'(regwrite), 32'd0);
        chk("rst alu_r", alu_r, 32'd7);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].instr, vecs[i].a, vecs[i].b);
            sb.push_back(vecs[i]);
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL v%0d scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d alu_r", i), alu_r, e.alu);
                chk($sformatf("v%0d zero", i), 32'(zero), 32'(e.alu == 32'd0));
                chk($sformatf("v%0d regwrite", i), 32'(regwrite), 32'(e.rw));
                chk($sformatf("v%0d gpio_we", i), 32'(gpio_we), 32'(e.gw));
                chk($sformatf("v%0d pcsrc", i), 32'(pcsrc), 32'(e.pc));
                chk($sformatf("v%0d stall_fetch", i), 32'(stall_fetch), 32'(e.pc != 2'b00));
                if (e.rw) chk($sformatf("v%0d regsel", i), 32'(regsel), 32'(e.rs));
            end
            drive(NOP, 32'd0, 32'd0);
        end

        drive({12'hABC, 5'd17, 3'b000, 5'd9, 7'b0010011}, 32'd0, 32'd0);
        chk("field rs1", 32'(rs1), 32'd17);
        chk("field rs2", 32'(rs2), 32'd28);
        chk("field rd", 32'(rd), 32'd9);
        chk("field imm12", 32'(imm12), 32'hABC);
        chk("field imm20", 32'(imm20), 32'hABC88);

        // taken branch squashes exactly one following instruction
        drive(enc_b(3'b000), 32'd5, 32'd5);
        chk("beq pcsrc", 32'(pcsrc), 32'd1);
        chk("beq stall", 32'(stall_fetch), 32'd1);
        drive(enc_i(12'd5, 3'b000, 7'b0010011), 32'd2, 32'd0);
        chk("bubble regwrite", 32'(regwrite), 32'd0);
        chk("bubble stall", 32'(stall_fetch), 32'd0);
        chk("bubble alu_r", alu_r, 32'd7);
        drive(enc_i(12'd5, 3'b000, 7'b0010011), 32'd2, 32'd0);
        chk("after bubble regwrite", 32'(regwrite), 32'd1);

        // back-to-back jal: second is squashed and cannot extend the flush
        drive({20'd0, 5'd1, 7'b1101111}, 32'd0, 32'd0);
        chk("jal1 pcsrc", 32'(pcsrc), 32'd2);
        drive({20'd0, 5'd1, 7'b1101111}, 32'd0, 32'd0);
        chk("jal2 pcsrc", 32'(pcsrc), 32'd0);
        chk("jal2 regwrite", 32'(regwrite), 32'd0);
        drive(enc_i(12'd5, 3'b000, 7'b0010011), 32'd2, 32'd0);
        chk("post jal regwrite", 32'(regwrite), 32'd1);

        // squashed GPIO write
        drive(enc_b(3'b000), 32'd1, 32'd1);
        drive(enc_i(12'hF02, 3'b001, 7'b1110011), 32'd0, 32'd0);
        chk("bubble gpio_we", 32'(gpio_we), 32'd0);
        drive(enc_i(12'hF02, 3'b001, 7'b1110011), 32'd0, 32'd0);
        chk("gpio after bubble", 32'(gpio_we), 32'd1);

        // reset during the flush cycle cancels the pending bubble
        drive(enc_b(3'b000), 32'd5, 32'd5);
        chk("pre-rst pcsrc", 32'(pcsrc), 32'd1);
        @(negedge clck);
        rst = 1'b1; instr = enc_i(12'd5, 3'b000, 7'b0010011); rs1_data = 32'd2;
        #1;
        chk("mid-rst regwrite", 32'(regwrite), 32'd0);
        chk("mid-rst pcsrc", 32'(pcsrc), 32'd0);
        @(negedge clck);
        rst = 1'b0;
        #1;
        chk("post-rst regwrite", 32'(regwrite), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv_exec_ctrl.md
# rv_exec_ctrl

Execute-stage decode, control and ALU block for the two-stage RV32I-subset CPU. It splits the instruction word held in EX into fields and generates all datapath controls: register write, write-back select, GPIO write and PC-source select. It computes the ALU result and resolves branches with that result. A single internal flop squashes the wrong-path instruction that follows any taken control transfer.

## Interface
- No parameters.
- clck  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction in EX.
- rs1_data  in  32  register-file read port 1 (ALU A, GPIO data, jalr base).
- rs2_data  in  32  register-file read port 2.
- rs1, rs2, rd  out  5 each  instr[19:15], instr[24:20], instr[11:7].
- imm12  out  12  instr[31:20].
- imm20  out  20  instr[31:12].
- alu_r  out  32  ALU result.
- zero  out  1  alu_r == 0.
- regwrite  out  1  register-file write enable.
- regsel  out  2  write-back select: 00 switch input, 01 {imm20,12'b0}, 10 alu_r, 11 link (PC+4).
- gpio_we  out  1  load hex display from rs1_data.
- pcsrc  out  2  next PC: 00 PC+1 word, 01 branch target, 10 jal target, 11 jalr target.
- stall_fetch  out  1  taken control transfer in EX this cycle.

## Operation
- B operand:
  - rs2_data when alusrc=0.
  - sign-extended instr[31:20] when alusrc=1.
- ALU op codes (4-bit; shift amount is B[4:0]; slt/sltu produce 0 or 1):
  - 0000 and, 0001 or, 0010 xor, 0011 add, 0100 sub.
  - 0101 mul (low 32 bits), 0110 mulh (signed x signed, high 32), 0111 mulhu (unsigned, high 32).
  - 1000 sll, 1001 srl, 1010 sra.
  - 1100 slt, 1101 sltu.
  - Unused codes give R=0.
- R-type (0110011): alusrc=0, regwrite=1, regsel=10.
  - add/sub selected by funct7[5].
  - and, or, xor, sll, srl, sra, slt, sltu by funct3/funct7.
  - funct7=0000001 with funct3 000/001/011 → mul/mulh/mulhu.
- I-type ALU (0010011): alusrc=1, regwrite=1, regsel=10.
  - addi, andi, ori, xori, slti, sltiu.
  - slli, srli, srai; srai selected by instr[30].
- lui (0110111): regwrite=1, regsel=01.
- csrrw (1110011, funct3 001):
  - imm12=0xF02: gpio_we=1, regwrite=0.
  - imm12=0xF00: regwrite=1, regsel=00.
  - Any other CSR: no effect.
- Branch (1100011): alusrc=0, regwrite=0.
  - beq/bne: op=sub; taken on zero / !zero.
  - blt/bge: op=slt; taken on R[0] / !R[0].
  - bltu/bgeu: op=sltu; same R[0] rule.
  - Taken → pcsrc=01.
- jal (1101111): regwrite=1, regsel=11, pcsrc=10.
- jalr (1100111): regwrite=1, regsel=11, pcsrc=11, op=add, alusrc=1.
- Writes to x0 are dropped by the register file, not here.
- Undefined opcode or funct: regwrite=0, gpio_we=0, pcsrc=00, op=add, alusrc=0.
- stall_fetch = (pcsrc != 00).
- Bubble, when stall_ex=1 or rst=1: regwrite, gpio_we and stall_fetch are 0, pcsrc=00. alu_r and the field outputs still follow instr.

## Timing
- Everything is combinational from instr, rs1_data and rs2_data, except stall_ex.
- stall_ex register:
  - Each rising edge, stall_ex <= stall_fetch.
  - rst sets it to 0; a reset mid-flush cancels the pending bubble.
- A taken branch or jump in cycle N turns the instruction in EX at cycle N+1 into a bubble. Cycle N+2 executes normally.
- Back-to-back jumps: the squashed one cannot set stall_fetch, so no double bubble.
- Outputs during reset: regwrite=0, gpio_we=0, pcsrc=00, stall_fetch=0.

## Structure
- Shared package rv_pkg:
  - Opcode constants.
  - ALU op enum (4-bit).
  - regsel and pcsrc encodings.
  - CSR addresses 0xF00 and 0xF02.
- Sub-modules:
  - rv_alu: pure combinational.
  - rv_decode: field split plus control table.
- Top holds the B mux, branch resolution and the stall_ex flop.

## Test plan
- R-type arithmetic: add x3,x1,x2 with rs1=7, rs2=5 → alu_r=12, regwrite=1, regsel=10. sub → 2. mulh with 0x80000000 × 2 → 0xFFFFFFFF.
- Shifts and compares: srai with rs1=0x80000000, imm 4 → 0xF8000000. sltiu with rs1=1, imm -1 → 1. slt with -1 vs 1 → 1.
- Branches: beq equal operands → pcsrc=01, stall_fetch=1. Next cycle, with any addi in instr → regwrite=0. The cycle after that → regwrite=1.
- bgeu with rs1=1, rs2=0xFFFFFFFF → not taken (pcsrc=00).
- jal/jalr: jal → pcsrc=10, regsel=11, regwrite=1. Following instruction bubbled.
- CSR/GPIO and reset:
  - csrrw x0,0xF02,x5 → gpio_we=1.
  - csrrw x6,0xF00 → regwrite=1, regsel=00.
  - lui 0x12345 → regsel=01.
  - rst asserted in the cycle after a taken branch → stall_ex=0 at the next edge, and all enables are 0 while rst=1.
